// File: rtl/atom_bus_pkg.sv
// atom_bus_pkg: bus-cycle state encoding, default timing and Atom board addresses
// shared by the Atom bus master and its phase timer.
package atom_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PHI1  = 2'd1,
        PHI2H = 2'd2,
        HOLD  = 2'd3
    } bus_state_t;

    localparam int DEF_PHI1_CLKS = 4;
    localparam int DEF_PHI2_CLKS = 4;

    localparam logic [15:0] ROMBOX_LATCH = 16'hBFFF;
    localparam logic [15:0] SWITCH_LATCH = 16'hBFFE;
    localparam logic [15:0] JUMPER_READ  = 16'hBFFD;
    localparam logic [15:0] EXT_ROM_BASE = 16'hA000;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/atom_bus_phase_timer.sv
// atom_bus_phase_timer: measures one bus phase. Cleared on phase entry, it counts
// the clocks already spent in the phase and flags the last one (done). It
// saturates there, so it never wraps inside a phase.
module atom_bus_phase_timer #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] len,
    output logic          done
);

    logic [CW-1:0] cnt;

    // Elapsed-clock counter: restart on phase entry, hold once the phase is done.
    always_ff @(posedge clk) begin
        if (reset || load)
            cnt <= '0;
        else if (!done)
            cnt <= cnt + 1'b1;
    end

    assign done = (cnt == len - 1'b1);

endmodule

// File: rtl/atom_bus_master.sv
// atom_bus_master: converts request/response commands into 6502-style Atom bus
// cycles (IDLE -> PHI1 -> PHI2H -> HOLD). Define ATOM_BUS_RDY_EN to add the Rdy
// input. When Rdy is added, a read that sees Rdy low at the end of PHI2 repeats
// its PHI1/PHI2 phases.
module atom_bus_master
    import atom_bus_pkg::*;
#(
    parameter int PHI1_CLKS = DEF_PHI1_CLKS,
    parameter int PHI2_CLKS = DEF_PHI2_CLKS
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic [15:0] ReqAddr,
    input  logic        ReqWrite,
    input  logic [7:0]  ReqData,
    output logic        RspValid,
    output logic [7:0]  RspData,
    output logic [15:0] Addr,
    output logic        RW,
    output logic        PHI2,
    output logic [7:0]  DataOut,
    output logic        DataOE,
    input  logic [7:0]  DataIn
`ifdef ATOM_BUS_RDY_EN
    ,
    input  logic        Rdy
`endif
);

    localparam int CW = $clog2(max2(PHI1_CLKS, PHI2_CLKS) + 1);

    bus_state_t    state;
    logic          wr_q;
    logic          accept;
    logic          load;
    logic          done;
    logic          retry;
    logic [CW-1:0] len;

    assign accept = (state == IDLE) && ReqValid && ReqReady;
    // A new phase starts on accept and at the end of every PHI1/PHI2H phase.
    assign load   = accept || (((state == PHI1) || (state == PHI2H)) && done);
    assign len    = (state == PHI2H) ? CW'(PHI2_CLKS) : CW'(PHI1_CLKS);

`ifdef ATOM_BUS_RDY_EN
    assign retry = !wr_q && !Rdy;
`else
    assign retry = 1'b0;
`endif

    atom_bus_phase_timer #(.CW(CW)) u_timer (
        .clk   (Clk),
        .reset (Reset),
        .load  (load),
        .len   (len),
        .done  (done)
    );

    // Bus-cycle FSM; every bus and response output is registered here.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            Addr     <= '0;
            RW       <= 1'b1;
            PHI2     <= 1'b0;
            DataOut  <= '0;
            DataOE   <= 1'b0;
            ReqReady <= 1'b1;
            RspValid <= 1'b0;
            RspData  <= '0;
            wr_q     <= 1'b0;
        end else begin
            RspValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        // Address and direction settle while PHI2 is still low.
                        Addr     <= ReqAddr;
                        RW       <= ~ReqWrite;
                        wr_q     <= ReqWrite;
                        ReqReady <= 1'b0;
                        if (ReqWrite)
                            DataOut <= ReqData;
                        state    <= PHI1;
                    end
                end
                PHI1: begin
                    if (done) begin
                        PHI2   <= 1'b1;
                        DataOE <= wr_q;
                        state  <= PHI2H;
                    end
                end
                PHI2H: begin
                    if (done) begin
                        PHI2 <= 1'b0;
                        if (retry) begin
                            // Slow device: repeat the whole cycle with the same Addr/RW.
                            state <= PHI1;
                        end else begin
                            if (!wr_q)
                                RspData <= DataIn;
                            RspValid <= 1'b1;
                            state    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // Write data stayed on the bus one clock past the PHI2 fall.
                    DataOE   <= 1'b0;
                    RW       <= 1'b1;
                    ReqReady <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
